// File: rtl/bids_sequencer.sv
// Host-side command sequencer for the bid FSM: expands INIT/UNLOCK/RAWOP
// commands into single-cycle op strobes and drives ROUND start/wait.
module bids_sequencer #(
  parameter int DATAWIDTH   = 32,
  parameter int STARTCYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_valid,
  input  logic [1:0]           host_cmd,
  input  logic [3:0]           host_op,
  input  logic [DATAWIDTH-1:0] host_data,
  input  logic [DATAWIDTH-1:0] host_key,
  input  logic [DATAWIDTH-1:0] val_x,
  input  logic [DATAWIDTH-1:0] val_y,
  input  logic [DATAWIDTH-1:0] val_z,
  output logic                 host_ready,
  output logic                 done,
  output logic [2:0]           done_err,
  output logic [DATAWIDTH-1:0] done_maxbid,
  output logic [3:0]           C_op,
  output logic [DATAWIDTH-1:0] C_data,
  output logic                 C_start,
  input  logic                 ready,
  input  logic [2:0]           err,
  input  logic                 roundOver,
  input  logic [DATAWIDTH-1:0] maxBid
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CMD_INIT   = 2'd0;
  localparam logic [1:0] CMD_ROUND  = 2'd1;
  localparam logic [1:0] CMD_UNLOCK = 2'd2;

  localparam logic [3:0] OP_UNLOCK = 4'd1;
  localparam logic [3:0] OP_LOCK   = 4'd2;
  localparam logic [3:0] OP_LOADX  = 4'd3;
  localparam logic [3:0] OP_LOADY  = 4'd4;
  localparam logic [3:0] OP_LOADZ  = 4'd5;

  localparam logic [2:0] ERR_TIMEOUT = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    START,
    WAITRND,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           last_idx;
  logic                 capture;
  logic [3:0]           op_d;
  logic [DATAWIDTH-1:0] data_d;
  logic [2:0]           err_d;
  logic [DATAWIDTH-1:0] mb_d;
  logic [3:0]           ent_op;
  logic [DATAWIDTH-1:0] ent_data;

  logic [1:0]           cmd_q;
  logic [3:0]           op_q;
  logic [DATAWIDTH-1:0] data_q;
  logic [DATAWIDTH-1:0] key_q;
  logic [DATAWIDTH-1:0] x_q;
  logic [DATAWIDTH-1:0] y_q;
  logic [DATAWIDTH-1:0] z_q;

  assign host_ready = (state_q == IDLE);
  assign done       = (state_q == DONE);
  assign last_idx   = (cmd_q == CMD_INIT) ? 2'd3 : 2'd0;

  // Op list entry selected by the captured command and list index
  always_comb begin
    ent_op   = op_q;
    ent_data = data_q;
    unique case (cmd_q)
      CMD_INIT: begin
        unique case (idx_q)
          2'd0: begin
            ent_op   = OP_LOADX;
            ent_data = x_q;
          end
          2'd1: begin
            ent_op   = OP_LOADY;
            ent_data = y_q;
          end
          2'd2: begin
            ent_op   = OP_LOADZ;
            ent_data = z_q;
          end
          default: begin
            ent_op   = OP_LOCK;
            ent_data = key_q;
          end
        endcase
      end
      CMD_UNLOCK: begin
        ent_op   = OP_UNLOCK;
        ent_data = key_q;
      end
      default: begin
        ent_op   = op_q;
        ent_data = data_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    op_d    = '0;
    data_d  = '0;
    err_d   = done_err;
    mb_d    = done_maxbid;
    unique case (state_q)
      IDLE: begin
        if (host_valid) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = (host_cmd == CMD_ROUND) ? START : ISSUE;
        end
      end
      ISSUE: begin
        if (ready) begin
          op_d    = ent_op;
          data_d  = ent_data;
          state_d = CHECK;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          err_d   = ERR_TIMEOUT;
          state_d = DONE;
        end
      end
      CHECK: begin
        if (err != 3'd0) begin
          err_d   = err;
          state_d = DONE;
        end else if (idx_q == last_idx) begin
          err_d   = 3'd0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ISSUE;
        end
      end
      START: begin
        if (cnt_q == CW'(STARTCYCLES - 1)) begin
          state_d = WAITRND;
        end
      end
      WAITRND: begin
        if (roundOver) begin
          err_d   = err;
          mb_d    = maxBid;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Dwell counter restarts on every state change and saturates
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      C_op        <= '0;
      C_data      <= '0;
      C_start     <= 1'b0;
      done_err    <= '0;
      done_maxbid <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      C_op        <= op_d;
      C_data      <= data_d;
      C_start     <= (state_d == START);
      done_err    <= err_d;
      done_maxbid <= mb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      cmd_q  <= host_cmd;
      op_q   <= host_op;
      data_q <= host_data;
      key_q  <= host_key;
      x_q    <= val_x;
      y_q    <= val_y;
      z_q    <= val_z;
    end
  end

endmodule

// File: tb/tb_bids_sequencer.sv
// Bench for bids_sequencer: emulated bid FSM responder plus a
// command-level reference model of op lists, error codes and latencies.
module tb_bids_sequencer;

  localparam int DW = 32;
  localparam int SC = 2;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_valid;
  logic [1:0]    host_cmd;
  logic [3:0]    host_op;
  logic [DW-1:0] host_data;
  logic [DW-1:0] host_key;
  logic [DW-1:0] val_x;
  logic [DW-1:0] val_y;
  logic [DW-1:0] val_z;
  logic          host_ready;
  logic          done;
  logic [2:0]    done_err;
  logic [DW-1:0] done_maxbid;
  logic [3:0]    C_op;
  logic [DW-1:0] C_data;
  logic          C_start;
  logic          ready;
  logic [2:0]    err;
  logic          roundOver;
  logic [DW-1:0] maxBid;

  bids_sequencer #(
    .DATAWIDTH  (DW),
    .STARTCYCLES(SC),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .host_valid (host_valid),
    .host_cmd   (host_cmd),
    .host_op    (host_op),
    .host_data  (host_data),
    .host_key   (host_key),
    .val_x      (val_x),
    .val_y      (val_y),
    .val_z      (val_z),
    .host_ready (host_ready),
    .done       (done),
    .done_err   (done_err),
    .done_maxbid(done_maxbid),
    .C_op       (C_op),
    .C_data     (C_data),
    .C_start    (C_start),
    .ready      (ready),
    .err        (err),
    .roundOver  (roundOver),
    .maxBid     (maxBid)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int cycle = 0;

  logic [3:0]    q_op[$];
  logic [DW-1:0] q_data[$];
  int            q_cyc[$];
  logic [3:0]    exp_op[$];
  logic [DW-1:0] exp_data[$];

  int            start_hi;
  int            fall_cyc;
  int            ndone;
  int            nd0;
  int            done_cyc;
  int            bad_idle;
  int            acc_cyc;
  logic          prev_cs;
  logic [2:0]    seen_err;
  logic [DW-1:0] seen_mb;
  logic          rdy_at_done;

  int            fail_at;
  logic [2:0]    fail_code;
  logic [2:0]    rnd_err;
  int            ready_mode;
  int            ready_from;
  int            ro_delay;
  bit            ro_in_start;
  logic [DW-1:0] mb_val;
  logic [DW-1:0] exp_mb;

  logic [1:0]    cur_cmd;
  logic [3:0]    cur_op;
  logic [DW-1:0] cur_data;
  logic [DW-1:0] cur_key;
  logic [DW-1:0] cur_x;
  logic [DW-1:0] cur_y;
  logic [DW-1:0] cur_z;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: observe at the falling edge, then drive the responder
  task automatic cyc();
    @(negedge clk);
    cycle++;
    if (C_op != 4'd0) begin
      q_op.push_back(C_op);
      q_data.push_back(C_data);
      q_cyc.push_back(cycle);
    end else if (C_data != '0) begin
      bad_idle++;
    end
    if (C_start) start_hi++;
    if (prev_cs && !C_start) fall_cyc = cycle;
    prev_cs = C_start;
    if (done) begin
      ndone++;
      done_cyc    = cycle;
      seen_err    = done_err;
      seen_mb     = done_maxbid;
      rdy_at_done = host_ready;
    end
    roundOver = (ro_in_start && C_start) ||
                (fall_cyc >= 0 && ro_delay >= 0 &&
                 cycle == fall_cyc + ro_delay);
    err = 3'd0;
    if (C_op != 4'd0 && q_op.size() == fail_at) err = fail_code;
    if (roundOver) err = rnd_err;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = ($urandom_range(0, 3) != 0);
      2:       ready = (cycle >= ready_from);
      default: ready = 1'b0;
    endcase
    maxBid = mb_val;
  endtask

  task automatic accept(input logic [1:0] cmd, input logic [3:0] op,
                        input logic [DW-1:0] data, input logic [DW-1:0] key,
                        input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input logic [DW-1:0] z);
    int b;
    b = 0;
    while (!host_ready && b < 3 * TO) begin
      cyc();
      b++;
    end
    chk("idle_ready", host_ready, 1);
    q_op.delete();
    q_data.delete();
    q_cyc.delete();
    start_hi = 0;
    fall_cyc = -1;
    prev_cs  = C_start;
    cur_cmd = cmd; cur_op = op; cur_data = data;
    cur_key = key; cur_x = x; cur_y = y; cur_z = z;
    host_valid = 1'b1;
    host_cmd   = cmd;
    host_op    = op;
    host_data  = data;
    host_key   = key;
    val_x      = x;
    val_y      = y;
    val_z      = z;
    acc_cyc = cycle;
    nd0     = ndone;
    cyc();
    chk("busy_ready", host_ready, 0);
    host_cmd  = 2'($urandom);
    host_op   = 4'($urandom);
    host_data = $urandom;
    host_key  = $urandom;
    val_x     = $urandom;
    val_y     = $urandom;
    val_z     = $urandom;
    cyc();
    host_valid = 1'b0;
  endtask

  // Reference model: expected op list, completion code and latency
  task automatic finish_cmd(input string tag);
    logic [2:0] ee;
    int lat;
    int b;
    exp_op.delete();
    exp_data.delete();
    case (cur_cmd)
      2'd0: begin
        exp_op.push_back(4'd3); exp_data.push_back(cur_x);
        exp_op.push_back(4'd4); exp_data.push_back(cur_y);
        exp_op.push_back(4'd5); exp_data.push_back(cur_z);
        exp_op.push_back(4'd2); exp_data.push_back(cur_key);
      end
      2'd2: begin
        exp_op.push_back(4'd1); exp_data.push_back(cur_key);
      end
      2'd3: begin
        exp_op.push_back(cur_op); exp_data.push_back(cur_data);
      end
      default: ;
    endcase
    lat = -1;
    ee  = 3'd0;
    if (cur_cmd == 2'd1) begin
      if (ro_delay >= 0 && ro_delay < TO) begin
        ee     = rnd_err;
        exp_mb = mb_val;
        lat    = ro_delay + 1;
      end else begin
        ee  = 3'd7;
        lat = TO;
      end
    end else if (ready_mode == 3) begin
      exp_op.delete();
      exp_data.delete();
      ee  = 3'd7;
      lat = TO + 2;
    end else if (fail_at >= 1 && fail_at <= exp_op.size()) begin
      while (exp_op.size() > fail_at) begin
        void'(exp_op.pop_back());
        void'(exp_data.pop_back());
      end
      ee = fail_code;
    end
    b = 0;
    while (ndone == nd0 && b < 4 * TO + 100) begin
      cyc();
      b++;
    end
    chk({tag, "_done_count"}, ndone - nd0, 1);
    chk({tag, "_done_err"}, seen_err, ee);
    chk({tag, "_done_maxbid"}, seen_mb, exp_mb);
    chk({tag, "_ready_in_done"}, rdy_at_done, 0);
    chk({tag, "_n_ops"}, q_op.size(), exp_op.size());
    for (int i = 0; i < exp_op.size() && i < q_op.size(); i++) begin
      chk({tag, "_op"}, q_op[i], exp_op[i]);
      chk({tag, "_data"}, q_data[i], exp_data[i]);
    end
    if (cur_cmd == 2'd1) begin
      chk({tag, "_start_cycles"}, start_hi, SC);
      chk({tag, "_wait_latency"}, done_cyc - fall_cyc, lat);
    end else if (lat >= 0) begin
      chk({tag, "_latency"}, done_cyc - acc_cyc, lat);
    end
    cyc();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_ready_after"}, host_ready, 1);
    chk({tag, "_err_hold"}, done_err, ee);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    r_cmd;
    logic [3:0]    r_op;
    reset = 1'b1; host_valid = 1'b0; host_cmd = '0; host_op = '0;
    host_data = '0; host_key = '0; val_x = '0; val_y = '0; val_z = '0;
    ready = 1'b0; err = '0; roundOver = 1'b0; maxBid = '0;
    start_hi = 0; fall_cyc = -1; ndone = 0; nd0 = 0; done_cyc = 0;
    bad_idle = 0; acc_cyc = 0; prev_cs = 1'b0; seen_err = '0;
    seen_mb = '0; rdy_at_done = 1'b0;
    fail_at = 0; fail_code = '0; rnd_err = '0; ready_mode = 0;
    ready_from = 0; ro_delay = -1; ro_in_start = 1'b0; mb_val = '0;
    exp_mb = '0;

    cyc();
    cyc();
    chk("rst_c_op", C_op, 0);
    chk("rst_c_data", C_data, 0);
    chk("rst_c_start", C_start, 0);
    chk("rst_done", done, 0);
    chk("rst_done_err", done_err, 0);
    chk("rst_maxbid", done_maxbid, 0);
    chk("rst_ready", host_ready, 1);

    // reset wins over a simultaneous command request
    host_valid = 1'b1;
    host_cmd   = 2'd0;
    cyc();
    reset      = 1'b0;
    host_valid = 1'b0;
    q_op.delete();
    nd0 = ndone;
    for (int i = 0; i < 4; i++) cyc();
    chk("rstprio_ready", host_ready, 1);
    chk("rstprio_ops", q_op.size(), 0);
    chk("rstprio_done", ndone - nd0, 0);

    ready_mode = 0;
    fail_at    = 0;
    accept(2'd0, 4'd0, 32'd0, 32'd12, 32'd45, 32'd46, 32'd47);
    finish_cmd("init_ok");
    if (q_cyc.size() == 4) begin
      chk("init_first_at", q_cyc[0] - acc_cyc, 2);
      for (int i = 1; i < 4; i++) chk("init_spacing", q_cyc[i] - q_cyc[i-1], 2);
    end

    fail_at   = 2;
    fail_code = 3'd1;
    accept(2'd0, 4'd0, 32'd0, 32'd12, 32'd45, 32'd46, 32'd47);
    finish_cmd("init_err");
    fail_at = 0;

    ro_delay = 5; ro_in_start = 1'b0; mb_val = 32'd2; rnd_err = 3'd0;
    accept(2'd1, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    finish_cmd("round_ok");

    ro_delay = -1; ro_in_start = 1'b1; mb_val = 32'd99;
    accept(2'd1, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    finish_cmd("round_timeout");

    ready_mode = 2;
    ready_from = cycle + 11;
    accept(2'd2, 4'd0, 32'd0, 32'd12, 32'd0, 32'd0, 32'd0);
    finish_cmd("unlock_late");
    if (q_cyc.size() == 1) chk("unlock_issue_at", q_cyc[0] - ready_from, 1);

    ready_mode = 3;
    accept(2'd2, 4'd0, 32'd0, 32'd12, 32'd0, 32'd0, 32'd0);
    finish_cmd("issue_timeout");

    ready_mode = 1;
    fail_at    = 1;
    fail_code  = 3'd3;
    accept(2'd3, 4'd12, 32'hCAFE_0012, 32'd0, 32'd0, 32'd0, 32'd0);
    finish_cmd("rawop_hi");
    fail_at = 0;

    // reset while C_start is high
    ro_delay = -1; ro_in_start = 1'b0; mb_val = 32'd5;
    accept(2'd1, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("rststart_cstart_hi", C_start, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_mb = '0;
    chk("rststart_cstart", C_start, 0);
    chk("rststart_ready", host_ready, 1);
    chk("rststart_maxbid", done_maxbid, 0);
    for (int i = 0; i < 8; i++) cyc();
    chk("rststart_no_done", ndone - nd0, 0);
    ready_mode = 0;
    accept(2'd0, 4'd0, 32'd0, 32'd7, 32'd1, 32'd2, 32'd3);
    finish_cmd("init_after_rst");

    for (int k = 0; k < 40; k++) begin
      r_cmd       = 2'($urandom_range(0, 3));
      r_op        = 4'($urandom_range(1, 15));
      fail_at     = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      fail_code   = 3'($urandom_range(1, 6));
      ready_mode  = ($urandom_range(0, 9) == 0) ? 3 : 1;
      ro_delay    = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TO + 3);
      ro_in_start = 1'($urandom_range(0, 1));
      mb_val      = $urandom;
      rnd_err     = 3'($urandom_range(0, 6));
      accept(r_cmd, r_op, $urandom, $urandom, $urandom, $urandom, $urandom);
      finish_cmd("rand");
    end

    chk("idle_data_zero", bad_idle, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/bids_sequencer.md
BIDS_SEQUENCER -- requirements
Module: bids_sequencer

Interface
REQ-001 Parameter DATAWIDTH, default 32: width of C_data, maxBid, host data and key.
REQ-002 Parameter STARTCYCLES, default 2: cycles C_start is held high per round.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles to wait for roundOver or ready.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 host_valid  input  1  command request; accepted when host_valid && host_ready.
REQ-007 host_cmd  input  2  0=INIT, 1=ROUND, 2=UNLOCK, 3=RAWOP.
REQ-008 host_op  input  4  opcode for RAWOP (NO_OP=0, UNLOCK=1, LOCK=2, LOADX=3, LOADY=4, LOADZ=5, SETMASK=6, SETTIMER=7, SETBIDCHARGE=8).
REQ-009 host_data  input  DATAWIDTH  RAWOP data.
REQ-010 host_key  input  DATAWIDTH  key for INIT lock and UNLOCK.
REQ-011 val_x, val_y, val_z  input  DATAWIDTH each  balances loaded by INIT.
REQ-012 host_ready  output  1  sequencer idle, can accept a command.
REQ-013 done  output  1  one-cycle pulse at command completion.
REQ-014 done_err  output  3  outerrors code of completed command (NOERROR=0 ... DUPLICATEBIDS=5); 7 = timeout.
REQ-015 done_maxbid  output  DATAWIDTH  maxBid captured by last ROUND.
REQ-016 C_op  output  4  opcode to bid FSM, registered.
REQ-017 C_data  output  DATAWIDTH  data to bid FSM, registered.
REQ-018 C_start  output  1  round start to bid FSM, registered.
REQ-019 ready, err(3), roundOver, maxBid(DATAWIDTH)  inputs  bid FSM status.

Function
REQ-020 Command captured (all host inputs latched) on the edge where host_valid && host_ready; host_ready low from next cycle until cycle after done.
REQ-021 States: IDLE, ISSUE, CHECK, START, WAITRND, DONE.
REQ-022 Op lists: INIT = LOADX(val_x), LOADY(val_y), LOADZ(val_z), LOCK(host_key); UNLOCK = UNLOCK(host_key); RAWOP = host_op(host_data); ROUND = no ops.
REQ-023 ISSUE: at an edge where ready==1, drive C_op/C_data with next list entry for exactly one cycle, go CHECK; C_op returns to NO_OP (0) and C_data to 0 otherwise.
REQ-024 CHECK: sample err one cycle after op presented; err!=0 -> DONE with done_err=err, remaining ops skipped; else next op (ISSUE) or DONE if list exhausted.
REQ-025 ISSUE waiting on ready longer than TIMEOUT cycles -> DONE, done_err=7.
REQ-026 ROUND: START drives C_start=1 for exactly STARTCYCLES cycles, then C_start=0 and WAITRND.
REQ-027 WAITRND: first cycle roundOver==1 -> latch maxBid into done_maxbid, DONE, done_err=err sampled same cycle; no roundOver within TIMEOUT cycles -> DONE, done_err=7, done_maxbid unchanged.
REQ-028 roundOver high during START is ignored.
REQ-029 DONE lasts one cycle: done=1, then IDLE; done_err holds until next done.
REQ-030 host_valid while busy ignored; no queuing.
REQ-031 Timeout counter width ceil(log2(TIMEOUT+1)), cleared on each state entry; no wrap.
REQ-032 Unknown host_cmd values impossible (2-bit fully decoded); RAWOP with host_op>8 issued unchanged, FSM err reported.

Reset
REQ-033 reset high at an edge: state IDLE, C_op=0, C_data=0, C_start=0, done=0, done_err=0, done_maxbid=0, host_ready=1 next cycle, counters 0.
REQ-034 Reset mid-command aborts it with no done pulse; C_start drops the cycle after the reset edge.
REQ-035 reset has priority over host_valid in same cycle.

Verification
REQ-036 INIT val 45/46/47, key 12, ready=1, err=0 -> C_op 3,4,5,2 each one cycle on alternate cycles, done, done_err=0.
REQ-037 INIT with err=1 after LOADY -> LOADZ/LOCK never issued, done_err=1.
REQ-038 ROUND, STARTCYCLES=2, roundOver 5 cycles after C_start falls with maxBid=2 -> C_start high exactly 2 cycles, done_maxbid=2, done_err=0.
REQ-039 ROUND, roundOver never asserted -> done after TIMEOUT cycles in WAITRND, done_err=7.
REQ-040 UNLOCK key 12 with ready=0 for 10 cycles then 1 -> C_op=1 issued cycle after ready rises, done_err=0.
REQ-041 reset asserted during START -> C_start 0 next cycle, no done, host_ready=1, new INIT then completes normally.
